// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard/sequencing controller for a 5-stage CPU. It sits beside
//   the IF/ID and ID/EX pipeline registers and generates the PC write-enable,
//   the IF/ID write-enable and flush, and the ID/EX flush. It handles:
//     - load-use stalls: a load in EX whose destination feeds the ID instruction
//     - taken-branch flushes: the branch is resolved in EX
//     - jump flushes: the jump target is resolved in ID
//     - front-end freeze while a multi-cycle mult/div executes
//
// Parameters
//   MULDIV_CYCLES  freeze length after a mult/div issues (1..255)
//   CNT_W          width of the freeze down-counter (must hold MULDIV_CYCLES-1)
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   ID_rs, ID_rt    source register fields of the instruction in ID
//   ID_UsesRt       the ID instruction reads rt
//   ID_Jump         ID holds j/jal/jr/jalr
//   ID_MulDivStart  ID holds mult/multu/div/divu
//   EX_MemRead      EX holds a load
//   EX_WriteReg     destination register of the EX instruction
//   EX_BranchTaken  the EX branch resolved taken
//   PC_Write        1: the PC updates on this edge
//   IF_ID_Write     1: IF/ID loads; 0: IF/ID holds
//   IF_ID_flush     1: IF/ID loads a NOP
//   ID_EX_flush     1: ID/EX loads a bubble
//   MulDiv_busy     registered; 1 while the front end is frozen for mult/div
//
// Build option
//   DELAY_SLOT_EN   when defined, the MIPS branch delay slot is honoured: the
//                   slot instruction is not flushed after a taken branch or
//                   after a jump.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UsesRt,
    input  logic       ID_Jump,
    input  logic       ID_MulDivStart,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_WriteReg,
    input  logic       EX_BranchTaken,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
    output logic       MulDiv_busy
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    // The counter is loaded with N-1 and the freeze ends on the cycle it reads
    // zero, so the freeze covers exactly MULDIV_CYCLES cycles.
    localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MULDIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q;
    logic             load_use;

    // Register 0 is hard-wired to zero, so a load to it never creates a hazard.
    assign load_use = EX_MemRead && (EX_WriteReg != 5'd0) &&
                      ((EX_WriteReg == ID_rs) ||
                       (ID_UsesRt && (EX_WriteReg == ID_rt)));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;

        unique case (state_q)
            RUN: begin
                if (EX_BranchTaken) begin
                    // The wrong-path fetch in IF is always discarded.
                    IF_ID_flush = 1'b1;
`ifdef DELAY_SLOT_EN
                    ID_EX_flush = 1'b0;
`else
                    ID_EX_flush = 1'b1;
`endif
                end else if (load_use) begin
                    // Hold PC and IF/ID, and insert a bubble; any jump or
                    // mult/div in ID is re-evaluated on the next cycle.
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_flush = 1'b1;
                end else if (ID_Jump) begin
`ifdef DELAY_SLOT_EN
                    IF_ID_flush = 1'b0;
`else
                    IF_ID_flush = 1'b1;
`endif
                end else if (ID_MulDivStart) begin
                    // The mult/div advances into EX normally on this cycle,
                    // and the front end freezes starting on the next one.
                    state_d = MD_BUSY;
                    count_d = MD_LAST;
                end
            end
            MD_BUSY: begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_flush = 1'b1;
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (reset) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= (state_d == MD_BUSY);
        end
    end

    assign MulDiv_busy = busy_q;

endmodule
